dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning dmem word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning dmem read latency in cycles (minimum 1).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports p0_req, p0_wren, input, 1 bit each: processor-side request and write flag.
REQ-007 SHALL have ports p0_addr [ADDR_W] and p0_wdata [DATA_W], input: processor address and write data.
REQ-008 SHALL have ports p0_ack, output, 1 bit, and p0_rdata, output, DATA_W: completion pulse and read data.
REQ-009 SHALL have ports p1_req, p1_wren, p1_addr, p1_wdata, p1_ack, p1_rdata, identical to port 0, for the loader/debug requester.
REQ-010 SHALL have ports address_dmem [ADDR_W], data [DATA_W] and wren [1], output: registered dmem drive.
REQ-011 SHALL have port q_dmem, input, DATA_W: dmem read data.
REQ-012 SHALL have ports busy, output, 1 bit, and grant_id, output, 1 bit: transaction in flight, and owner of the current or last grant.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT and RESP.
REQ-014 SHALL sample p0_req/p1_req only in IDLE; if any is high, SHALL latch winner, wren, addr and wdata, then go to ISSUE.
REQ-015 SHALL arbitrate round-robin: with one request, grant it; with both, grant the port not equal to grant_id.
REQ-016 SHALL in ISSUE drive address_dmem=latched addr, data=latched wdata, wren=latched wren, for exactly one cycle.
REQ-017 SHALL go ISSUE->RESP for writes and ISSUE->WAIT for reads.
REQ-018 SHALL stay in WAIT RD_LAT cycles using a counter, capture q_dmem into the winner's rdata on the last WAIT cycle, then go to RESP.
REQ-019 SHALL in RESP pulse the winner's ack high for exactly one cycle, then return to IDLE.
REQ-020 SHALL give latency from req sampled in IDLE (cycle n) to ack high of n+2 for a write and n+2+RD_LAT for a read.
REQ-021 SHALL hold each pX_rdata stable from capture until that port's next read capture.
REQ-022 SHALL complete an in-flight transaction if the requester drops req before ack (ack still pulses; write still performed).
REQ-023 SHALL resample both requests in IDLE after RESP, so a continuously asserted req gets a new transaction at most every 3 (write) or 3+RD_LAT (read) cycles and two continuous requesters alternate.
REQ-024 SHALL keep wren=0 in all states except ISSUE-with-write; address_dmem and data SHALL hold their last value outside ISSUE.
REQ-025 SHALL assert busy in ISSUE, WAIT and RESP, and deassert it in IDLE.
REQ-026 SHALL never assert p0_ack and p1_ack in the same cycle.

Reset
REQ-027 SHALL, on reset low, immediately and asynchronously force state=IDLE, wren=0, p0_ack=p1_ack=0, busy=0, grant_id=1 (port 0 wins the first tie), address_dmem=0, data=0, p0_rdata=p1_rdata=0, and WAIT counter=0.
REQ-028 SHALL abort any in-flight transaction on reset without issuing ack; it SHALL sample requests on the first rising edge after reset returns high.

Structure
REQ-029 SHALL place the state encoding (2-bit IDLE=0, ISSUE=1, WAIT=2, RESP=3) and default ADDR_W/DATA_W/RD_LAT constants in shared package dmem_arb_pkg.
REQ-030 SHALL isolate the two-input round-robin pick in sub-module rr_pick2 (inputs req[1:0] and last; output winner and any).

Verification
REQ-031 SHALL cover: p0 write addr=0x010 wdata=0xDEADBEEF alone -> wren high one cycle at n+1 with address_dmem=0x010; p0_ack at n+2; p1_ack never.
REQ-032 SHALL cover: p1 read addr=0x020 with memory holding 0x12345678, RD_LAT=1 -> p1_ack at n+3 with p1_rdata=0x12345678; p0_rdata unchanged.
REQ-033 SHALL cover: p0 and p1 both held high from reset release -> grant order 0,1,0,1 and acks never coincident.
REQ-034 SHALL cover: p0 drops req during WAIT -> p0_ack still pulses once and the state returns to IDLE.
REQ-035 SHALL cover: reset pulled low during ISSUE of a write -> wren=0 and busy=0 within the same cycle, no ack, and grant_id=1.
REQ-036 SHALL cover: RD_LAT=3 read -> ack at n+5 with rdata equal to q_dmem sampled on the third WAIT cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Width of the read-latency counter; it counts 0..lat-1 and never drops below one bit.
  function automatic int cnt_width(input int lat);
    if (lat > 1) begin
      return $clog2(lat);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin pick: on a tie the port that did not win last time goes next.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // Winner selection from the current requests and the previous owner
  always_comb begin
    winner = 1'b0;
    any    = |req;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous data memory; one transaction
// at a time, registered memory drive and registered per-port ack/rdata.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              busy,
  output logic              grant_id
);

  localparam int              CNT_W    = cnt_width(RD_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_grant;
  logic              r_wr_lat;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wren;
  logic [1:0]        r_ack;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_winner;
  logic              w_any;
  logic              w_last;
  logic              w_sel_wren;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .req    ({p1_req, p0_req}),
    .last   (r_grant),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_sel_wren  = w_winner ? p1_wren  : p0_wren;
  assign w_sel_addr  = w_winner ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_winner ? p1_wdata : p0_wdata;
  assign w_last      = (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (r_wr_lat) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_last) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch, memory drive, wait counter, read capture and ack pulse.
  // The memory drive is loaded on the grant edge so it is valid for the whole ISSUE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_grant  <= 1'b1;
      r_wr_lat <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_data   <= {DATA_W{1'b0}};
      r_wren   <= 1'b0;
      r_ack    <= 2'b00;
      r_busy   <= 1'b0;
      r_rdata0 <= {DATA_W{1'b0}};
      r_rdata1 <= {DATA_W{1'b0}};
    end else begin
      r_ack  <= 2'b00;
      r_wren <= 1'b0;
      r_busy <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_winner;
            r_wr_lat <= w_sel_wren;
            r_addr   <= w_sel_addr;
            r_data   <= w_sel_wdata;
            r_wren   <= w_sel_wren;
          end
        end
        ISSUE: begin
          r_cnt <= {CNT_W{1'b0}};
          if (r_wr_lat) begin
            r_ack[r_grant] <= 1'b1;
          end
        end
        WAIT: begin
          if (w_last) begin
            r_cnt          <= {CNT_W{1'b0}};
            r_ack[r_grant] <= 1'b1;
            if (r_grant) begin
              r_rdata1 <= q_dmem;
            end else begin
              r_rdata0 <= q_dmem;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP:    r_cnt <= {CNT_W{1'b0}};
        default: r_cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign address_dmem = r_addr;
  assign data         = r_data;
  assign wren         = r_wren;
  assign p0_ack       = r_ack[0];
  assign p1_ack       = r_ack[1];
  assign p0_rdata     = r_rdata0;
  assign p1_rdata     = r_rdata1;
  assign busy         = r_busy;
  assign grant_id     = r_grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single transactions on an RD_LAT=1
// instance plus hand-written arbitration, drop, reset and RD_LAT=3 sequences.
module tb_dmem_arbiter;

  typedef struct {
    logic        port;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance 1: RD_LAT = 1, backed by a memory model
  logic        rst1;
  logic        p0_req1, p0_wren1, p1_req1, p1_wren1;
  logic [11:0] p0_addr1, p1_addr1;
  logic [31:0] p0_wdata1, p1_wdata1;
  logic        p0_ack1, p1_ack1;
  logic [31:0] p0_rdata1, p1_rdata1;
  logic [11:0] addr1;
  logic [31:0] data1;
  logic        wren1;
  logic [31:0] q1;
  logic        busy1, gid1;

  // instance 2: RD_LAT = 3, read data is a per-cycle pattern
  logic        rst2;
  logic        p0_req2, p0_wren2, p1_req2, p1_wren2;
  logic [11:0] p0_addr2, p1_addr2;
  logic [31:0] p0_wdata2, p1_wdata2;
  logic        p0_ack2, p1_ack2;
  logic [31:0] p0_rdata2, p1_rdata2;
  logic [11:0] addr2;
  logic [31:0] data2;
  logic        wren2;
  logic [31:0] q2;
  logic        busy2, gid2;
  logic [15:0] cyc = 16'd0;

  logic [31:0] mem [0:4095];
  logic [31:0] exp_rd [0:1];

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clock(clk), .reset(rst1),
    .p0_req(p0_req1), .p0_wren(p0_wren1), .p0_addr(p0_addr1), .p0_wdata(p0_wdata1),
    .p0_ack(p0_ack1), .p0_rdata(p0_rdata1),
    .p1_req(p1_req1), .p1_wren(p1_wren1), .p1_addr(p1_addr1), .p1_wdata(p1_wdata1),
    .p1_ack(p1_ack1), .p1_rdata(p1_rdata1),
    .address_dmem(addr1), .data(data1), .wren(wren1), .q_dmem(q1),
    .busy(busy1), .grant_id(gid1)
  );

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3)) u_dut2 (
    .clock(clk), .reset(rst2),
    .p0_req(p0_req2), .p0_wren(p0_wren2), .p0_addr(p0_addr2), .p0_wdata(p0_wdata2),
    .p0_ack(p0_ack2), .p0_rdata(p0_rdata2),
    .p1_req(p1_req2), .p1_wren(p1_wren2), .p1_addr(p1_addr2), .p1_wdata(p1_wdata2),
    .p1_ack(p1_ack2), .p1_rdata(p1_rdata2),
    .address_dmem(addr2), .data(data2), .wren(wren2), .q_dmem(q2),
    .busy(busy2), .grant_id(gid2)
  );

  always @(posedge clk) begin
    if (wren1) mem[addr1] <= data1;
    q1  <= mem[addr1];
    cyc <= cyc + 16'd1;
  end
  assign q2 = {16'hA5A5, cyc};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int n_own;
    int n_oth;
    logic own;
    logic oth;
    lat = 0; n_own = 0; n_oth = 0;
    @(negedge clk);
    if (v.port) begin
      p1_req1 = 1'b1; p1_wren1 = v.wr; p1_addr1 = v.addr; p1_wdata1 = v.wdata;
    end else begin
      p0_req1 = 1'b1; p0_wren1 = v.wr; p0_addr1 = v.addr; p0_wdata1 = v.wdata;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        p0_req1 = 1'b0; p1_req1 = 1'b0;
        chk("issue_wren", {31'd0, wren1}, {31'd0, v.wr});
        chk("issue_addr", {20'd0, addr1}, {20'd0, v.addr});
        chk("issue_busy", {31'd0, busy1}, 32'd1);
        chk("grant_id", {31'd0, gid1}, {31'd0, v.port});
        if (v.wr) chk("issue_data", data1, v.wdata);
      end
      own = v.port ? p1_ack1 : p0_ack1;
      oth = v.port ? p0_ack1 : p1_ack1;
      if (own) begin
        n_own++;
        if (lat == 0) lat = k;
      end
      if (oth) n_oth++;
    end
    chk("ack_latency", lat, v.wr ? 32'd2 : 32'd3);
    chk("ack_count", n_own, 32'd1);
    chk("other_ack", n_oth, 32'd0);
    chk("idle_busy", {31'd0, busy1}, 32'd0);
    if (!v.wr) exp_rd[v.port] = v.exp;
    chk("own_rdata", v.port ? p1_rdata1 : p0_rdata1, exp_rd[v.port]);
    chk("other_rdata", v.port ? p0_rdata1 : p1_rdata1, exp_rd[~v.port]);
  endtask

  initial begin
    vec_t vecs [9];
    int order [4];
    int n_ord;
    int n_coinc;
    int n_ack;
    int lat;
    logic [31:0] q_third;

    vecs[0] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 12'h020, 32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 12'h020, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 12'hFFF, 32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 12'hFFF, 32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b1, 12'h000, 32'hA5A55A5A, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 12'h000, 32'h0,        32'hA5A55A5A};
    vecs[8] = '{1'b1, 1'b0, 12'h001, 32'h0,        32'h0};

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    rst1 = 1'b0; rst2 = 1'b0;
    p0_req1 = 1'b0; p0_wren1 = 1'b0; p0_addr1 = 12'h0; p0_wdata1 = 32'h0;
    p1_req1 = 1'b0; p1_wren1 = 1'b0; p1_addr1 = 12'h0; p1_wdata1 = 32'h0;
    p0_req2 = 1'b0; p0_wren2 = 1'b0; p0_addr2 = 12'h0; p0_wdata2 = 32'h0;
    p1_req2 = 1'b0; p1_wren2 = 1'b0; p1_addr2 = 12'h0; p1_wdata2 = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_wren", {31'd0, wren1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_grant", {31'd0, gid1}, 32'd1);
    chk("rst_acks", {30'd0, p1_ack1, p0_ack1}, 32'd0);
    chk("rst_addr", {20'd0, addr1}, 32'd0);
    chk("rst_data", data1, 32'd0);
    chk("rst_rdata0", p0_rdata1, 32'd0);
    chk("rst_rdata1", p1_rdata1, 32'd0);
    rst1 = 1'b1; rst2 = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // p0 drops req during WAIT; the read still completes with one ack
    @(negedge clk);
    p0_req1 = 1'b1; p0_wren1 = 1'b0; p0_addr1 = 12'h010;
    n_ack = 0; lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("drop_busy_wait", {31'd0, busy1}, 32'd1);
        p0_req1 = 1'b0;
      end
      if (p0_ack1) begin
        n_ack++;
        if (lat == 0) lat = k;
      end
      if (p1_ack1) n_ack = n_ack + 100;
    end
    chk("drop_ack_count", n_ack, 32'd1);
    chk("drop_ack_lat", lat, 32'd3);
    chk("drop_rdata", p0_rdata1, 32'hDEADBEEF);
    chk("drop_idle", {31'd0, busy1}, 32'd0);

    // reset asserted in the middle of a write's ISSUE cycle
    @(negedge clk);
    p0_req1 = 1'b1; p0_wren1 = 1'b1; p0_addr1 = 12'h030; p0_wdata1 = 32'h0BADF00D;
    @(negedge clk);
    p0_req1 = 1'b0;
    chk("rstmid_wren_before", {31'd0, wren1}, 32'd1);
    chk("rstmid_grant_before", {31'd0, gid1}, 32'd0);
    #2 rst1 = 1'b0;
    #1;
    chk("rstmid_wren", {31'd0, wren1}, 32'd0);
    chk("rstmid_busy", {31'd0, busy1}, 32'd0);
    chk("rstmid_grant", {31'd0, gid1}, 32'd1);
    n_ack = 0;
    @(negedge clk);
    rst1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (p0_ack1 || p1_ack1) n_ack++;
      @(negedge clk);
    end
    chk("rstmid_no_ack", n_ack, 32'd0);
    chk("rstmid_no_write", mem[12'h030], 32'd0);

    // both ports held high from reset release: grants alternate starting at port 0
    rst1 = 1'b0;
    p0_req1 = 1'b1; p0_wren1 = 1'b1; p0_addr1 = 12'h100; p0_wdata1 = 32'h11111111;
    p1_req1 = 1'b1; p1_wren1 = 1'b1; p1_addr1 = 12'h101; p1_wdata1 = 32'h22222222;
    @(negedge clk);
    rst1 = 1'b1;
    n_ord = 0; n_coinc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (p0_ack1 && p1_ack1) n_coinc++;
      if (n_ord < 4 && (p0_ack1 || p1_ack1)) begin
        order[n_ord] = p1_ack1 ? 1 : 0;
        n_ord++;
      end
    end
    p0_req1 = 1'b0; p1_req1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("rr_ack_seen", n_ord, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_ord) chk("rr_order", order[i], i % 2);
    end
    chk("rr_coincident", n_coinc, 32'd0);
    chk("rr_mem0", mem[12'h100], 32'h11111111);
    chk("rr_mem1", mem[12'h101], 32'h22222222);

    // RD_LAT=3 read: ack five cycles after sampling, data from the third WAIT cycle
    @(negedge clk);
    p1_req2 = 1'b1; p1_wren2 = 1'b0; p1_addr2 = 12'h005;
    n_ack = 0; lat = 0; q_third = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) p1_req2 = 1'b0;
      if (k == 4) q_third = q2;
      if (p1_ack2) begin
        n_ack++;
        if (lat == 0) lat = k;
      end
      if (p0_ack2) n_ack = n_ack + 100;
    end
    chk("lat3_ack_lat", lat, 32'd5);
    chk("lat3_ack_count", n_ack, 32'd1);
    chk("lat3_rdata", p1_rdata2, q_third);
    chk("lat3_p0_rdata", p0_rdata2, 32'd0);
    chk("lat3_idle", {31'd0, busy2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
